// File: rtl/ftb_entry_encoder.sv
// FTB entry encoder: compresses commit-time updates into packed FTB entries and queues them for the FTB write port.
// Optional statistics counters are enabled with `define FTB_ENCODER_STAT_EN.
package ftb_pkg;
    localparam int unsigned XLEN               = 64;
    localparam int unsigned FTB_FALLTHRU_WIDTH = 5;
    localparam int unsigned FTB_TARGET_WIDTH   = 12;
    localparam int unsigned FHW = XLEN - FTB_FALLTHRU_WIDTH - 1;
    localparam int unsigned THW = XLEN - FTB_TARGET_WIDTH - 1;

    typedef enum logic [1:0] {BT_NONE, BT_COND, BT_JAL, BT_JALR} branch_type_e;
    typedef enum logic [1:0] {TAR_FIT, TAR_OVF, TAR_UDF} tar_stat_e;

    typedef struct packed {
        logic                          carry;
        logic [FTB_FALLTHRU_WIDTH-1:0] fallthruAddr;
        tar_stat_e                     tarStat;
        logic [FTB_TARGET_WIDTH-1:0]   targetAddr;
        branch_type_e                  branch_type;
    } ftbInfo_t;

    function automatic logic [XLEN-1:0] get_fallthru_addr(input logic [XLEN-1:0] start,
                                                         input ftbInfo_t e);
        logic [FHW-1:0] hi;
        hi = start[XLEN-1:FTB_FALLTHRU_WIDTH+1] + FHW'(e.carry);
        return {hi, e.fallthruAddr, 1'b0};
    endfunction

    function automatic logic [XLEN-1:0] get_target_addr(input logic [XLEN-1:0] start,
                                                       input ftbInfo_t e);
        logic [THW-1:0] hi;
        hi = start[XLEN-1:FTB_TARGET_WIDTH+1];
        case (e.tarStat)
            TAR_OVF: hi = hi + THW'(1);
            TAR_UDF: hi = hi - THW'(1);
            default: hi = hi;
        endcase
        return {hi, e.targetAddr, 1'b0};
    endfunction
endpackage

module ftb_entry_encoder
    import ftb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
`ifdef FTB_ENCODER_STAT_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 upd_valid,
    output logic                 upd_ready,
    input  logic [XLEN-1:0]      upd_startAddr,
    input  logic [XLEN-1:0]      upd_fallthruAddr,
    input  logic [XLEN-1:0]      upd_targetAddr,
    input  branch_type_e         upd_branch_type,
    input  logic                 upd_taken,
    input  logic                 upd_mispred,
    input  logic                 upd_hit_on_ftb,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic [XLEN-1:0]      wr_startAddr,
    output ftbInfo_t             wr_entry,
`ifdef FTB_ENCODER_STAT_EN
    output logic [CNT_W-1:0]     stat_write_cnt,
    output logic [CNT_W-1:0]     stat_drop_cnt,
`endif
    output logic                 drop_pulse
);
    localparam int unsigned FW = FTB_FALLTHRU_WIDTH;
    localparam int unsigned TW = FTB_TARGET_WIDTH;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FHW-1:0] start_fhi, start_fhi_inc, fall_hi;
    logic [THW-1:0] start_thi, start_thi_inc, start_thi_dec, tgt_hi;
    logic           fall_ok, tgt_ok, encodable, candidate, accept;
    logic           push, pop, drop;
    ftbInfo_t       enc;

    logic [XLEN-1:0] mem_start [DEPTH];
    ftbInfo_t        mem_entry [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            full, empty;

    assign start_fhi     = upd_startAddr[XLEN-1:FW+1];
    assign start_fhi_inc = start_fhi + FHW'(1);
    assign fall_hi       = upd_fallthruAddr[XLEN-1:FW+1];
    assign start_thi     = upd_startAddr[XLEN-1:TW+1];
    assign start_thi_inc = start_thi + THW'(1);
    assign start_thi_dec = start_thi - THW'(1);
    assign tgt_hi        = upd_targetAddr[XLEN-1:TW+1];

    always_comb begin
        enc              = '0;
        fall_ok          = 1'b1;
        tgt_ok           = 1'b1;
        enc.fallthruAddr = upd_fallthruAddr[FW:1];
        enc.targetAddr   = upd_targetAddr[TW:1];
        enc.branch_type  = upd_branch_type;
        if (fall_hi == start_fhi)          enc.carry = 1'b0;
        else if (fall_hi == start_fhi_inc) enc.carry = 1'b1;
        else                               fall_ok   = 1'b0;
        if (tgt_hi == start_thi)           enc.tarStat = TAR_FIT;
        else if (tgt_hi == start_thi_inc)  enc.tarStat = TAR_OVF;
        else if (tgt_hi == start_thi_dec)  enc.tarStat = TAR_UDF;
        else                               tgt_ok      = 1'b0;
    end

    assign encodable = fall_ok && tgt_ok;
    assign candidate = upd_mispred || (upd_taken && !upd_hit_on_ftb);
    assign accept    = upd_valid && upd_ready && !flush;
    assign push      = accept && candidate && encodable;
    assign drop      = accept && candidate && !encodable;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign upd_ready = !full;
    assign wr_valid  = !empty;
    assign pop       = wr_valid && wr_ready && !flush;

    // Gate the data outputs on occupancy so they show zero whenever the FIFO is empty, including during reset.
    assign wr_startAddr = empty ? '0 : mem_start[rd_ptr];
    assign wr_entry     = empty ? '0 : mem_entry[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_start[wr_ptr] <= upd_startAddr;
            mem_entry[wr_ptr] <= enc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= drop;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef FTB_ENCODER_STAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_write_cnt <= '0;
            stat_drop_cnt  <= '0;
        end else begin
            if (wr_valid && wr_ready && stat_write_cnt != '1)
                stat_write_cnt <= stat_write_cnt + CNT_W'(1);
            if (drop_pulse && stat_drop_cnt != '1)
                stat_drop_cnt <= stat_drop_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
